// File: rtl/ranger_pkg.sv
// ranger_pkg: shared types and constants for the ultrasonic ranger.
//   state_t        - ranger FSM states
//   *_DEF          - default timing and speed-band constants (100 MHz clk)
//   CARRIER_PERIOD - PWM carrier period, shared with the motor PWM stage
//   band_pw()      - maps an echo count to a PWM compare value
package ranger_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        DONE
    } state_t;

    localparam int CYC_W = 22;   // echo / timer counter width
    localparam int PER_W = 23;   // period counter width
    localparam int PW_W  = 19;   // PWM compare width

    localparam int unsigned TRIG_CYCLES_DEF    = 1000;
    localparam int unsigned PERIOD_CYCLES_DEF  = 6_000_000;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 3_802_000;
    localparam int unsigned BAND1_DEF          = 475250;
    localparam int unsigned BAND2_DEF          = 950500;
    localparam int unsigned BAND3_DEF          = 1425750;
    localparam int unsigned PW_STEP_DEF        = 62500;
    localparam int unsigned CARRIER_PERIOD     = 250000;

    // Nearer obstacle -> shorter echo -> slower motor. Anything beyond the
    // third band runs at full carrier.
    function automatic logic [PW_W-1:0] band_pw(
        input logic [CYC_W-1:0] n,
        input logic [CYC_W-1:0] b1,
        input logic [CYC_W-1:0] b2,
        input logic [CYC_W-1:0] b3,
        input logic [PW_W-1:0]  step
    );
        if (n <= b1)      return step;
        else if (n <= b2) return step + step;
        else if (n <= b3) return step + step + step;
        else              return PW_W'(CARRIER_PERIOD);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge: two-flop synchroniser for an asynchronous input plus a
// registered previous value for edge detection.
//   clk, rst - clock, asynchronous active-high reset
//   d        - asynchronous input
//   level    - synchronised level
//   rise     - one-cycle pulse on a synchronised 0->1 transition
//   fall     - one-cycle pulse on a synchronised 1->0 transition
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: fires the HC-SR04 trigger every PERIOD_CYCLES, times
// the echo pulse and turns the result into a PWM compare value.
//   clk, rst    - 100 MHz clock, asynchronous active-high reset
//   echo        - raw sensor echo (asynchronous)
//   enable      - motor enable; low forces pulse_width to 0
//   trig        - sensor trigger
//   echo_cycles - last measured echo high time (clk cycles)
//   pulse_width - PWM compare value (0 .. CARRIER_PERIOD)
//   valid       - one-cycle strobe when a result is published
//   timeout     - last result was a timeout
module ultrasonic_ranger
    import ranger_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES    = TRIG_CYCLES_DEF,
    parameter int unsigned PERIOD_CYCLES  = PERIOD_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned BAND1          = BAND1_DEF,
    parameter int unsigned BAND2          = BAND2_DEF,
    parameter int unsigned BAND3          = BAND3_DEF,
    parameter int unsigned PW_STEP        = PW_STEP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             echo,
    input  logic             enable,
    output logic             trig,
    output logic [CYC_W-1:0] echo_cycles,
    output logic [PW_W-1:0]  pulse_width,
    output logic             valid,
    output logic             timeout
);

    localparam logic [CYC_W-1:0] TRIG_LAST = CYC_W'(TRIG_CYCLES - 1);
    localparam logic [CYC_W-1:0] TIMEOUT   = CYC_W'(TIMEOUT_CYCLES);
    localparam logic [PER_W-1:0] PER_LAST  = PER_W'(PERIOD_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [PER_W-1:0] period_cnt;
    logic             period_wrap;
    logic [CYC_W-1:0] timer;
    logic [CYC_W-1:0] timer_next;
    logic [CYC_W-1:0] timer_inc;
    logic             load_result;
    logic             result_timeout;
    logic             echo_level;
    logic             echo_rise;
    logic             echo_fall;

    sync_edge u_echo_sync (
        .clk   (clk),
        .rst   (rst),
        .d     (echo),
        .level (echo_level),
        .rise  (echo_rise),
        .fall  (echo_fall)
    );

    // Free-running from reset, so it reads 0 on every trigger start and the
    // first trigger lands PERIOD_CYCLES after reset release.
    assign period_wrap = (period_cnt == PER_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) period_cnt <= '0;
        else     period_cnt <= period_wrap ? '0 : period_cnt + PER_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    assign timer_inc = timer + CYC_W'(1);

    // One timer serves as trigger-length counter, rise-wait timer and echo
    // count; it is cleared on every state change that needs it.
    always_comb begin
        state_next     = state;
        timer_next     = timer;
        load_result    = 1'b0;
        result_timeout = 1'b0;
        unique case (state)
            IDLE: begin
                timer_next = '0;
                if (period_wrap) state_next = TRIG;
            end
            TRIG: begin
                if (timer == TRIG_LAST) begin
                    state_next = WAIT_RISE;
                    timer_next = '0;
                end else begin
                    timer_next = timer_inc;
                end
            end
            WAIT_RISE: begin
                if (echo_rise) begin
                    state_next = MEASURE;
                    timer_next = CYC_W'(1);
                end else if (timer_inc == TIMEOUT) begin
                    state_next     = DONE;
                    load_result    = 1'b1;
                    result_timeout = 1'b1;
                end else begin
                    timer_next = timer_inc;
                end
            end
            MEASURE: begin
                if (echo_fall) begin
                    state_next  = DONE;
                    load_result = 1'b1;
                end else if (echo_level) begin
                    if (timer_inc == TIMEOUT) begin
                        state_next     = DONE;
                        load_result    = 1'b1;
                        result_timeout = 1'b1;
                    end else begin
                        timer_next = timer_inc;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                timer_next = '0;
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    // Results are loaded on the edge into DONE so they are already visible
    // while valid is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_cycles <= '0;
            timeout     <= 1'b0;
            pulse_width <= '0;
        end else begin
            if (load_result) begin
                echo_cycles <= result_timeout ? TIMEOUT : timer;
                timeout     <= result_timeout;
            end
            if (!enable) begin
                pulse_width <= '0;
            end else if (load_result) begin
                pulse_width <= result_timeout ? PW_W'(CARRIER_PERIOD)
                             : band_pw(timer, CYC_W'(BAND1), CYC_W'(BAND2),
                                       CYC_W'(BAND3), PW_W'(PW_STEP));
            end
        end
    end

    assign trig  = (state == TRIG);
    assign valid = (state == DONE);

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb_ultrasonic_ranger: self-checking bench for ultrasonic_ranger with
// scaled-down timing so whole measurement periods fit in a short run.
module tb_ultrasonic_ranger;

    localparam int TRIG = 10;
    localparam int PER  = 700;
    localparam int TO   = 380;
    localparam int B1   = 95;
    localparam int B2   = 190;
    localparam int B3   = 285;
    localparam int STEP = 62500;
    localparam int FULL = 250000;

    logic        clk = 1'b0;
    logic        rst;
    logic        echo;
    logic        enable;
    logic        trig;
    logic [21:0] echo_cycles;
    logic [18:0] pulse_width;
    logic        valid;
    logic        timeout;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int model_pw  = 0;

    ultrasonic_ranger #(
        .TRIG_CYCLES    (TRIG),
        .PERIOD_CYCLES  (PER),
        .TIMEOUT_CYCLES (TO),
        .BAND1          (B1),
        .BAND2          (B2),
        .BAND3          (B3),
        .PW_STEP        (STEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .echo        (echo),
        .enable      (enable),
        .trig        (trig),
        .echo_cycles (echo_cycles),
        .pulse_width (pulse_width),
        .valid       (valid),
        .timeout     (timeout)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end, expected finish before 200000 cycles");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int actual, input int expected);
        total_cnt++;
        if (actual == expected) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    // Reference: bands are equal-width multiples of B1, so the band index is
    // ceil(n/B1) capped at 4; a missing rise or an echo of TO or more is a
    // timeout at full speed.
    function automatic bit ref_timeout(input int w);
        return (w == 0) || (w >= TO);
    endfunction

    function automatic int ref_pw(input int w, input bit en);
        int idx;
        if (!en) return 0;
        if (ref_timeout(w)) return FULL;
        idx = (w + B1 - 1) / B1;
        if (idx > 4) idx = 4;
        return idx * STEP;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic run_period(input int delay, input int width, input bit en,
                              input bit pre_high, input int exp_cyc,
                              input int exp_pw, input bit exp_to,
                              input string tag);
        int k;
        int hi;
        int lat;
        bit got;
        enable = en;
        if (!en) model_pw = 0;
        echo = pre_high;
        @(negedge clk);
        check({tag, ".pw_hold"}, int'(pulse_width), model_pw);
        k = 0;
        while (!trig && k < PER + 5) begin
            @(negedge clk);
            k++;
        end
        if (!trig) begin
            check({tag, ".trig_start"}, 0, 1);
            echo = 1'b0;
            return;
        end
        hi = 0;
        while (trig && hi < TRIG + 5) begin
            hi++;
            @(negedge clk);
        end
        check({tag, ".trig_width"}, hi, TRIG);
        got = 1'b0;
        lat = 0;
        for (int t = 0; t < delay + width + TO + 10; t++) begin
            if (valid) begin
                got = 1'b1;
                lat = t;
                break;
            end
            echo = pre_high || (width > 0 && t >= delay && t < delay + width);
            @(negedge clk);
        end
        echo = 1'b0;
        check({tag, ".valid_seen"}, int'(got), 1);
        if (got) begin
            check({tag, ".echo_cycles"}, int'(echo_cycles), exp_cyc);
            check({tag, ".pulse_width"}, int'(pulse_width), exp_pw);
            check({tag, ".timeout"}, int'(timeout), int'(exp_to));
            if (width == 0 || pre_high) check({tag, ".to_latency"}, lat, TO);
            @(negedge clk);
            check({tag, ".valid_single"}, int'(valid), 0);
        end
        model_pw = exp_pw;
    endtask

    // Release reset, check the first trigger timing, then consume the
    // echo-less first period (timeout result).
    task automatic release_and_first(input string tag);
        int k;
        bit got;
        rst = 1'b0;
        k = 0;
        while (k < PER + 5) begin
            @(negedge clk);
            k++;
            if (trig) break;
        end
        check({tag, ".first_trig"}, k, PER);
        got = 1'b0;
        for (int t = 0; t < 2 * PER; t++) begin
            if (valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, ".first_valid"}, int'(got), 1);
        check({tag, ".first_timeout"}, int'(timeout), 1);
        check({tag, ".first_pw"}, int'(pulse_width), enable ? FULL : 0);
        model_pw = enable ? FULL : 0;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".trig"}, int'(trig), 0);
        check({tag, ".echo_cycles"}, int'(echo_cycles), 0);
        check({tag, ".pulse_width"}, int'(pulse_width), 0);
        check({tag, ".valid"}, int'(valid), 0);
        check({tag, ".timeout"}, int'(timeout), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int    delay;
        int    width;
        bit    en;
        bit    pre_high;
        int    exp_cyc;
        int    exp_pw;
        bit    exp_to;
        string name;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{50, 20,  1'b1, 1'b0, 20,  62500,  1'b0, "basic"};
        vecs[1]  = '{30, 95,  1'b1, 1'b0, 95,  62500,  1'b0, "band1_edge"};
        vecs[2]  = '{30, 96,  1'b1, 1'b0, 96,  125000, 1'b0, "band1_over"};
        vecs[3]  = '{30, 190, 1'b1, 1'b0, 190, 125000, 1'b0, "band2_edge"};
        vecs[4]  = '{30, 191, 1'b1, 1'b0, 191, 187500, 1'b0, "band2_over"};
        vecs[5]  = '{30, 285, 1'b1, 1'b0, 285, 187500, 1'b0, "band3_edge"};
        vecs[6]  = '{30, 286, 1'b1, 1'b0, 286, 250000, 1'b0, "band3_over"};
        vecs[7]  = '{0,  0,   1'b1, 1'b0, 380, 250000, 1'b1, "no_echo"};
        vecs[8]  = '{0,  0,   1'b1, 1'b1, 380, 250000, 1'b1, "stuck_high"};
        vecs[9]  = '{40, 120, 1'b1, 1'b0, 120, 125000, 1'b0, "after_stuck"};
        vecs[10] = '{40, 200, 1'b0, 1'b0, 200, 0,      1'b0, "disabled"};
        vecs[11] = '{40, 200, 1'b1, 1'b0, 200, 187500, 1'b0, "reenabled"};

        rst    = 1'b1;
        echo   = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        release_and_first("reset");

        for (int i = 0; i < 12; i++) begin
            run_period(vecs[i].delay, vecs[i].width, vecs[i].en, vecs[i].pre_high,
                       vecs[i].exp_cyc, vecs[i].exp_pw, vecs[i].exp_to, vecs[i].name);
        end

        // enable low drops pulse_width on the next cycle; raising it again
        // does not restore the old value.
        enable = 1'b0;
        @(negedge clk);
        check("en_drop.pw", int'(pulse_width), 0);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("en_rise.pw", int'(pulse_width), 0);
        model_pw = 0;

        // randomized periods against the reference model
        for (int i = 0; i < 16; i++) begin
            int  r;
            int  w;
            int  d;
            bit  en;
            r  = int'($urandom_range(0, 9));
            d  = int'($urandom_range(1, 100));
            en = ($urandom_range(0, 4) != 0);
            if (r == 0)      w = 0;
            else if (r == 1) w = int'($urandom_range(390, 420));
            else             w = int'($urandom_range(1, 370));
            run_period(d, w, en, 1'b0, ref_timeout(w) ? TO : w,
                       ref_pw(w, en), ref_timeout(w), "random");
        end

        // reset in the middle of a measurement
        run_period(20, 50, 1'b1, 1'b0, 50, 62500, 1'b0, "pre_reset");
        begin
            int k;
            k = 0;
            while (!trig && k < PER + 5) begin
                @(negedge clk);
                k++;
            end
            check("mid_reset.trig_start", int'(trig), 1);
            k = 0;
            while (trig && k < TRIG + 5) begin
                @(negedge clk);
                k++;
            end
            for (int t = 0; t < 50; t++) begin
                echo = (t >= 10);
                @(negedge clk);
            end
            rst = 1'b1;
            #1;
            check_reset_outputs("mid_reset");
            repeat (3) @(negedge clk);
            echo = 1'b0;
            release_and_first("mid_reset");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
